bg_map_scroller: RTL and testbench
==================================

// Module: bg_map_scroller
// PURPOSE
//  Write-side owner of the background tile-map RAM; the background engine only reads it.
//  Once per frame (in vblank), advances the 4-bit fine scroll x_offset by speed.
//  On every 16-pixel carry, shifts the scrolling rows of the map one tile left and fills the new right column.
//  Drives port B of the dual-port tile RAM. The engine owns port A, so no arbitration is needed.
// PARAMETERS
//  TILE_COLS        40        tiles per map row (640/16)
//  TILE_ROWS        30        tile rows in map (480/16)
//  SCROLL_ROW_START 7         first scrolled row; rows above are the static HUD (y<=100)
//  LFSR_SEED        16'hACE1  LFSR reset value (only used with BG_LFSR_FILL_EN)
// PORTS
//  clk          in   1   system clock
//  reset        in   1   synchronous, active-high reset
//  frame_tick   in   1   1-cycle pulse at start of vblank
//  scroll_en    in   1   1 = scrolling active
//  speed        in   4   pixels advanced per frame, 0..15
//  fill_tile    in   16  tile word for new column cell; must be valid in the same cycle as fill_row
//  fill_row     out  5   map row currently being filled
//  ram_addr     out  16  tile RAM port B address = row*TILE_COLS + col
//  ram_wr_data  out  16  write data
//  ram_we       out  1   write strobe
//  ram_rd_data  in   16  port B read data, 1-cycle synchronous latency
//  x_offset     out  4   fine scroll offset to background engine
//  busy         out  1   shift in progress
//  shift_done   out  1   1-cycle pulse when a full map shift completes
//  overrun      out  1   1-cycle pulse: frame_tick arrived while busy
//  distance     out  16  count of completed column shifts; wraps at 16'hFFFF->0
// BEHAVIOUR
//  Reset values: state IDLE, x_offset=0, ram_we=0, ram_addr=0, ram_wr_data=0, busy=0, shift_done=0,
//    overrun=0, distance=0, fill_row=0, LFSR=LFSR_SEED.
//  Reset mid-shift aborts at once; the map is left partially shifted and is reloaded by game logic.
//  IDLE, on frame_tick with scroll_en=1: sum[4:0] = x_offset + speed; x_offset <= sum[3:0] on the next edge.
//    sum[4]=1 -> go to RD with r=SCROLL_ROW_START, c=0, busy=1.
//    sum[4]=0 -> stay in IDLE.
//  frame_tick with scroll_en=0 or speed=0 has no effect.
//  frame_tick while busy: ignored; x_offset is unchanged; overrun pulses.
//  RD: ram_addr = r*TILE_COLS + c + 1; ram_we=0.
//  WR: ram_addr = r*TILE_COLS + c; ram_wr_data = ram_rd_data; ram_we=1.
//    c < TILE_COLS-2 -> c++ and back to RD; otherwise go to FILL.
//  FILL: ram_addr = r*TILE_COLS + TILE_COLS-1; fill_row=r; ram_wr_data=fill_tile; ram_we=1.
//    r < TILE_ROWS-1 -> r++, c=0, go to RD; otherwise go to DONE.
//  DONE: busy=0; shift_done=1; distance++; return to IDLE.
//  Cost: 2 cycles per copied cell. Total = (TILE_ROWS-SCROLL_ROW_START)*(2*(TILE_COLS-1)+1) + 1
//    = 1818 cycles with defaults, well inside vblank.
//  ram_we is high only in WR/FILL; no write ever targets rows < SCROLL_ROW_START.
//  Address arithmetic is 16-bit unsigned; max address 1199 with defaults.
// CONFIGURATION
//  BG_LFSR_FILL_EN defined: fill_tile is ignored.
//    16-bit Fibonacci LFSR, taps 16,14,13,11, steps once per FILL.
//    Fill word = 16'h0100 (enabled, tile 0,0) when r==TILE_ROWS-1 (ground row).
//    Fill word = {7'b0, lfsr[3:0]==0, 2'b00, 3'd1, lfsr[6:4]} for other rows (sparse obstacles).
//  BG_LFSR_FILL_EN undefined: fill_tile is used directly; no LFSR logic exists.
// STRUCTURE
//  Shared package bg_map_pkg:
//    TILE_WIDTH/HEIGHT, TILE_COLS/ROWS, SCROLL_ROW_START.
//    Tile-word field constants: COL[2:0], ROW[5:3], XFLIP[6], YFLIP[7], ENABLE[8].
//    State encoding: IDLE, RD, WR, FILL, DONE.
//  One sub-module: bg_lfsr16 (clk, reset, step, seed -> value), instantiated only under BG_LFSR_FILL_EN.
// TESTING
//  Use a RAM model with 1-cycle read latency.
//  1. Reset, then frame_tick with speed=5, scroll_en=1, x3:
//     x_offset 5,10,15; no ram_we; busy=0.
//  2. x_offset=15, speed=3, frame_tick: x_offset=2, busy=1.
//     Each row r>=7: col c holds old col c+1; col 39 = fill_tile; rows 0..6 untouched.
//     shift_done pulses 1818 cycles after the tick; distance=1.
//  3. Second frame_tick 100 cycles into a shift: overrun pulses; x_offset unchanged; shift completes normally.
//  4. reset asserted mid-shift (row 12): next cycle ram_we=0, busy=0, x_offset=0, distance=0.
//  5. scroll_en=0 or speed=0 with frame_tick: no state change, no RAM access.
//  6. BG_LFSR_FILL_EN: after reset, the first shift writes 16'h0100 at address 29*40+39.
//     Other col-39 fills match the reference LFSR sequence from 16'hACE1.

Source files
------------

// File: rtl/bg_map_pkg.sv
// Shared constants, tile-word field layout, scroller state encoding and a
// tile-word builder for the background map write side.
package bg_map_pkg;

  localparam int unsigned TILE_WIDTH       = 16;
  localparam int unsigned TILE_HEIGHT      = 16;
  localparam int unsigned TILE_COLS        = 40;
  localparam int unsigned TILE_ROWS        = 30;
  localparam int unsigned SCROLL_ROW_START = 7;
  localparam logic [15:0] LFSR_SEED_DEF    = 16'hACE1;

  // Tile word fields: COL[2:0], ROW[5:3], XFLIP[6], YFLIP[7], ENABLE[8]
  localparam int unsigned TW_COL_LSB = 0;
  localparam int unsigned TW_ROW_LSB = 3;
  localparam int unsigned TW_XFLIP   = 6;
  localparam int unsigned TW_YFLIP   = 7;
  localparam int unsigned TW_ENABLE  = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_WR,
    ST_FILL,
    ST_DONE
  } state_e;

  function automatic logic [15:0] tile_word(input logic       en,
                                            input logic       yflip,
                                            input logic       xflip,
                                            input logic [2:0] row,
                                            input logic [2:0] col);
    logic [15:0] w;
    w                            = '0;
    w[TW_ENABLE]                 = en;
    w[TW_YFLIP]                  = yflip;
    w[TW_XFLIP]                  = xflip;
    w[TW_ROW_LSB+2 : TW_ROW_LSB] = row;
    w[TW_COL_LSB+2 : TW_COL_LSB] = col;
    return w;
  endfunction

endpackage

// File: rtl/bg_lfsr16.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11), right-shifting, loaded with seed
// on reset and advanced by one position per step pulse.
module bg_lfsr16 (
  input  logic        clk,
  input  logic        reset,
  input  logic        step,
  input  logic [15:0] seed,
  output logic [15:0] value
);

  logic [15:0] lfsr_q;
  logic        fb;

  assign fb    = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
  assign value = lfsr_q;

  // Shift register: reload seed on reset, advance on step
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_q <= seed;
    end else if (step) begin
      lfsr_q <= {fb, lfsr_q[15:1]};
    end
  end

endmodule

// File: rtl/bg_map_scroller.sv
// Background tile-map scroller: advances the fine x scroll once per frame and,
// on each 16-pixel carry, shifts the scrolling rows one tile left through
// port B of the tile RAM, filling the new right-hand column.
// Optional feature macro: BG_LFSR_FILL_EN (procedural fill from an LFSR
// instead of the fill_tile input).
module bg_map_scroller #(
  parameter int unsigned TILE_COLS        = bg_map_pkg::TILE_COLS,
  parameter int unsigned TILE_ROWS        = bg_map_pkg::TILE_ROWS,
  parameter int unsigned SCROLL_ROW_START = bg_map_pkg::SCROLL_ROW_START,
  parameter logic [15:0] LFSR_SEED        = bg_map_pkg::LFSR_SEED_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic        scroll_en,
  input  logic [3:0]  speed,
  input  logic [15:0] fill_tile,
  output logic [4:0]  fill_row,
  output logic [15:0] ram_addr,
  output logic [15:0] ram_wr_data,
  output logic        ram_we,
  input  logic [15:0] ram_rd_data,
  output logic [3:0]  x_offset,
  output logic        busy,
  output logic        shift_done,
  output logic        overrun,
  output logic [15:0] distance
);

  import bg_map_pkg::*;

  localparam logic [15:0] COLS16     = 16'(TILE_COLS);
  localparam logic [5:0]  LAST_COPY  = 6'(TILE_COLS - 2);
  localparam logic [4:0]  LAST_ROW   = 5'(TILE_ROWS - 1);
  localparam logic [4:0]  FIRST_ROW  = 5'(SCROLL_ROW_START);
  localparam logic [15:0] FIRST_BASE = 16'(SCROLL_ROW_START * TILE_COLS);

  state_e      state_q;
  logic [4:0]  r_q;
  logic [5:0]  c_q;
  logic [15:0] base_q;        // r_q * TILE_COLS, kept incrementally
  logic [3:0]  x_offset_q;
  logic [15:0] ram_addr_q;
  logic        ram_we_q;
  logic        busy_q;
  logic        shift_done_q;
  logic        overrun_q;
  logic [15:0] distance_q;
  logic [4:0]  fill_row_q;
  logic [4:0]  sum;
  logic [15:0] fill_word;

  assign sum = {1'b0, x_offset_q} + {1'b0, speed};

`ifdef BG_LFSR_FILL_EN
  logic [15:0] lfsr_val;

  bg_lfsr16 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .step  (state_q == ST_FILL),
    .seed  (LFSR_SEED),
    .value (lfsr_val)
  );

  // Ground row is solid; other rows get sparse obstacles from the LFSR
  always_comb begin
    fill_word = '0;
    if (r_q == LAST_ROW) begin
      fill_word = tile_word(1'b1, 1'b0, 1'b0, 3'd0, 3'd0);
    end else begin
      fill_word = tile_word(lfsr_val[3:0] == 4'h0, 1'b0, 1'b0, 3'd1, lfsr_val[6:4]);
    end
  end
`else
  // New column cells come straight from the game logic
  always_comb begin
    fill_word = fill_tile;
  end
`endif

  // Write data follows the state combinationally: the copied word only
  // arrives from the RAM during WR, and fill_tile is valid alongside fill_row.
  always_comb begin
    ram_wr_data = '0;
    case (state_q)
      ST_WR:   ram_wr_data = ram_rd_data;
      ST_FILL: ram_wr_data = fill_word;
      default: ram_wr_data = '0;
    endcase
  end

  // Scroll/shift FSM; address and strobe are registered for the state being entered
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      r_q          <= '0;
      c_q          <= '0;
      base_q       <= '0;
      x_offset_q   <= '0;
      ram_addr_q   <= '0;
      ram_we_q     <= 1'b0;
      busy_q       <= 1'b0;
      shift_done_q <= 1'b0;
      overrun_q    <= 1'b0;
      distance_q   <= '0;
      fill_row_q   <= '0;
    end else begin
      shift_done_q <= 1'b0;
      overrun_q    <= frame_tick && busy_q;
      case (state_q)
        ST_IDLE: begin
          if (frame_tick && scroll_en && (speed != '0)) begin
            x_offset_q <= sum[3:0];
            if (sum[4]) begin
              state_q    <= ST_RD;
              r_q        <= FIRST_ROW;
              c_q        <= '0;
              base_q     <= FIRST_BASE;
              ram_addr_q <= FIRST_BASE + 16'd1;
              ram_we_q   <= 1'b0;
              busy_q     <= 1'b1;
            end
          end
        end
        ST_RD: begin
          state_q    <= ST_WR;
          ram_addr_q <= base_q + 16'(c_q);
          ram_we_q   <= 1'b1;
        end
        ST_WR: begin
          if (c_q < LAST_COPY) begin
            state_q    <= ST_RD;
            c_q        <= c_q + 6'd1;
            ram_addr_q <= base_q + 16'(c_q) + 16'd2;
            ram_we_q   <= 1'b0;
          end else begin
            state_q    <= ST_FILL;
            ram_addr_q <= base_q + COLS16 - 16'd1;
            fill_row_q <= r_q;
            ram_we_q   <= 1'b1;
          end
        end
        ST_FILL: begin
          if (r_q < LAST_ROW) begin
            state_q    <= ST_RD;
            r_q        <= r_q + 5'd1;
            c_q        <= '0;
            base_q     <= base_q + COLS16;
            ram_addr_q <= base_q + COLS16 + 16'd1;
            ram_we_q   <= 1'b0;
          end else begin
            state_q  <= ST_DONE;
            ram_we_q <= 1'b0;
          end
        end
        ST_DONE: begin
          state_q      <= ST_IDLE;
          busy_q       <= 1'b0;
          shift_done_q <= 1'b1;
          distance_q   <= distance_q + 16'd1;
        end
        default: begin
          state_q  <= ST_IDLE;
          ram_we_q <= 1'b0;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign fill_row   = fill_row_q;
  assign ram_addr   = ram_addr_q;
  assign ram_we     = ram_we_q;
  assign x_offset   = x_offset_q;
  assign busy       = busy_q;
  assign shift_done = shift_done_q;
  assign overrun    = overrun_q;
  assign distance   = distance_q;

endmodule

// File: tb/tb_bg_map_scroller.sv
// Directed self-checking bench for bg_map_scroller with a 1-cycle-latency
// tile RAM model and a reference map model (honours BG_LFSR_FILL_EN).
module tb_bg_map_scroller;

  localparam int NCELLS = 1200;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        frame_tick = 1'b0;
  logic        scroll_en = 1'b0;
  logic [3:0]  speed = 4'd0;
  logic [15:0] fill_tile;
  logic [4:0]  fill_row;
  logic [15:0] ram_addr;
  logic [15:0] ram_wr_data;
  logic        ram_we;
  logic [15:0] ram_rd_data = 16'd0;
  logic [3:0]  x_offset;
  logic        busy;
  logic        shift_done;
  logic        overrun;
  logic [15:0] distance;

  logic        ram_load = 1'b1;
  logic [15:0] mem     [0:NCELLS-1];
  logic [15:0] exp_mem [0:NCELLS-1];
  logic [15:0] ref_lfsr = 16'hACE1;
  int          we_cnt = 0;
  int          low_wr = 0;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  assign fill_tile = 16'hF000 | {11'b0, fill_row};

  bg_map_scroller dut (
    .clk         (clk),
    .reset       (reset),
    .frame_tick  (frame_tick),
    .scroll_en   (scroll_en),
    .speed       (speed),
    .fill_tile   (fill_tile),
    .fill_row    (fill_row),
    .ram_addr    (ram_addr),
    .ram_wr_data (ram_wr_data),
    .ram_we      (ram_we),
    .ram_rd_data (ram_rd_data),
    .x_offset    (x_offset),
    .busy        (busy),
    .shift_done  (shift_done),
    .overrun     (overrun),
    .distance    (distance)
  );

  // Port B of the tile RAM: synchronous read, write-after-read on same address
  always @(posedge clk) begin
    if (ram_load) begin
      for (int i = 0; i < NCELLS; i++) mem[i] <= 16'(i) ^ 16'h5A00;
    end else begin
      ram_rd_data <= mem[ram_addr];
      if (ram_we) mem[ram_addr] <= ram_wr_data;
    end
  end

  always @(posedge clk) begin
    if (ram_we) begin
      we_cnt <= we_cnt + 1;
      if (ram_addr < 16'd280) low_wr <= low_wr + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
  endfunction

  function automatic logic [15:0] fill_ref(input int r, input logic [15:0] l);
`ifdef BG_LFSR_FILL_EN
    if (r == 29) return 16'h0100;
    return {7'b0, l[3:0] == 4'h0, 2'b00, 3'd1, l[6:4]};
`else
    return 16'hF000 | 16'(r) | (l & 16'h0000);
`endif
  endfunction

  task automatic apply_shift();
    for (int r = 7; r < 30; r++) begin
      for (int c = 0; c < 39; c++) exp_mem[r*40+c] = exp_mem[r*40+c+1];
      exp_mem[r*40+39] = fill_ref(r, ref_lfsr);
      ref_lfsr = lfsr_step(ref_lfsr);
    end
  endtask

  task automatic check_map(input string tag);
    int nb;
    nb = 0;
    for (int i = 0; i < NCELLS; i++) if (mem[i] !== exp_mem[i]) nb++;
    check(tag, nb, 0);
  endtask

  task automatic tick();
    @(posedge clk); #1 frame_tick = 1'b1;
    @(posedge clk); #1 frame_tick = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(posedge clk); #1 n++;
    end while (!shift_done && n < 4000);
  endtask

  initial begin
    int n;
    int we0;
    for (int i = 0; i < NCELLS; i++) exp_mem[i] = 16'(i) ^ 16'h5A00;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst x_offset", x_offset, 0);
    check("rst busy", busy, 0);
    check("rst ram_we", ram_we, 0);
    check("rst ram_addr", ram_addr, 0);
    check("rst wr_data", ram_wr_data, 0);
    check("rst distance", distance, 0);
    check("rst shift_done", shift_done, 0);
    check("rst overrun", overrun, 0);
    check("rst fill_row", fill_row, 0);
    ram_load = 1'b0;
    reset = 1'b0;

    // Fine scroll without carry
    scroll_en = 1'b1; speed = 4'd5;
    tick(); check("x 5", x_offset, 5);
    tick(); check("x 10", x_offset, 10);
    tick(); check("x 15", x_offset, 15);
    check("no carry busy", busy, 0);
    check("no carry we", we_cnt, 0);

    // First shift: 15+3 carries
    speed = 4'd3;
    tick();
    check("carry x", x_offset, 2);
    check("carry busy", busy, 1);
    wait_done(n);
    check("shift1 done seen", shift_done, 1);
    check("shift1 latency", n, 1818);
    check("shift1 distance", distance, 1);
    check("shift1 busy", busy, 0);
    check("shift1 writes", we_cnt, 920);
    @(posedge clk); #1;
    check("done pulse width", shift_done, 0);
    apply_shift();
    check_map("shift1 map");

    // Overrun: tick 100 cycles into a shift (2+15 carries)
    speed = 4'd15;
    tick();
    check("shift2 x", x_offset, 1);
    repeat (99) @(posedge clk);
    tick();
    check("overrun pulse", overrun, 1);
    check("overrun x unchanged", x_offset, 1);
    check("overrun busy", busy, 1);
    @(posedge clk); #1;
    check("overrun one cycle", overrun, 0);
    wait_done(n);
    check("shift2 done seen", shift_done, 1);
    check("shift2 distance", distance, 2);
    check("shift2 x", x_offset, 1);
    apply_shift();
    check_map("shift2 map");

    // scroll_en=0 or speed=0: no effect
    we0 = we_cnt;
    scroll_en = 1'b0; speed = 4'd9;
    tick();
    check("disabled x", x_offset, 1);
    check("disabled busy", busy, 0);
    scroll_en = 1'b1; speed = 4'd0;
    tick();
    check("speed0 x", x_offset, 1);
    check("speed0 busy", busy, 0);
    repeat (3) @(posedge clk); #1;
    check("idle no writes", we_cnt, we0);
    check("idle distance", distance, 2);

    // Reset in the middle of row 12
    speed = 4'd9;
    tick(); check("x 10 again", x_offset, 10);
    tick(); check("shift3 x", x_offset, 3);
    n = 0;
    do begin
      @(posedge clk); #1 n++;
    end while (!(ram_addr >= 16'd485 && ram_addr < 16'd520) && n < 2000);
    check("reached row 12", (ram_addr >= 16'd485 && ram_addr < 16'd520), 1);
    reset = 1'b1;
    @(posedge clk); #1;
    check("abort ram_we", ram_we, 0);
    check("abort busy", busy, 0);
    check("abort x", x_offset, 0);
    check("abort distance", distance, 0);
    reset = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < NCELLS; i++) exp_mem[i] = mem[i];
    ref_lfsr = 16'hACE1;

    // Full shift after reset (LFSR restarts from its seed)
    speed = 4'd15;
    tick(); check("post-rst x 15", x_offset, 15);
    tick(); check("post-rst x 14", x_offset, 14);
    wait_done(n);
    check("shift4 latency", n, 1818);
    check("shift4 distance", distance, 1);
    apply_shift();
    check_map("shift4 map");
`ifdef BG_LFSR_FILL_EN
    check("ground fill", mem[29*40+39], 16'h0100);
`else
    check("ground fill", mem[29*40+39], 16'hF01D);
`endif
    check("last fill_row", fill_row, 29);
    check("hud untouched", low_wr, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
